simon_input_checker: RTL and testbench

SIMON_INPUT_CHECKER -- requirements
Module: simon_input_checker

---
 rtl/simon_pkg.sv | 42 ++++
 rtl/key_debouncer.sv | 52 +++++
 rtl/simon_input_checker.sv | 175 +++++++++++++++++
 tb/tb_simon_input_checker.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// ============================================================================
// Module      : simon_pkg
// Description : Shared types, constants and helpers for the Simon input checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

    typedef logic [1:0] symbol_t;

    localparam int MAX_ROUND = 100;
    localparam int NUM_KEYS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_RESULT       = 2'd3
    } chk_state_t;

    function automatic logic round_len_ok(input logic [6:0] len);
        return (len != 7'd0) && (len <= 7'(MAX_ROUND));
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for a one-hot vector; callers qualify with is_onehot4.
    function automatic symbol_t key_to_sym(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// Module      : key_debouncer
// Description : 2-flop synchronizer plus counter debouncer for one active-low
//               push-button; output is the active-high debounced pressed state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pressed
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable_n;
    logic [c_CNT_W-1:0] r_cnt;

    // Counter tracks consecutive samples disagreeing with the stable level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable_n <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable_n) begin
                if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable_n <= r_sync2;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pressed = ~r_stable_n;

endmodule

`default_nettype wire

// File: rtl/simon_input_checker.sv
// ============================================================================
// Module      : simon_input_checker
// Description : Checks one round of debounced key presses against the expected
//               Simon sequence. Optional press timeout: SIMON_INPUT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_input_checker
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 150000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       start,
    input  logic [6:0] round_len,
    output logic [6:0] exp_idx,
    input  logic [1:0] exp_sym,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [3:0] press_leds,
    output logic [6:0] step
);

    logic [3:0] w_pressed;
    logic [3:0] r_pressed_d;
    logic [3:0] w_edge;
    logic       w_timeout;
    symbol_t    w_sym;

    chk_state_t r_state;
    chk_state_t w_state_nxt;
    logic [6:0] r_step;
    logic [6:0] w_step_nxt;
    logic [6:0] r_len;
    logic [6:0] w_len_nxt;
    logic       r_pass;
    logic       w_pass_nxt;
    logic       r_fail;
    logic       w_fail_nxt;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debouncer (
                .clk       (clk),
                .rst       (rst),
                .i_key_n   (key[gi]),
                .o_pressed (w_pressed[gi])
            );
        end
    endgenerate

    // A press is a rising edge of the debounced state, so keys held at start
    // stay invisible until released and pressed again.
    assign w_edge = w_pressed & ~r_pressed_d;
    assign w_sym  = key_to_sym(w_edge);

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Held at zero outside WAIT_PRESS, so every entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_WAIT_PRESS) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT_PRESS) &&
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam logic c_TIMEOUT_OFF = (TIMEOUT_CYCLES < 0);

    assign w_timeout = c_TIMEOUT_OFF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_step      <= 7'd0;
            r_len       <= 7'd0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_pressed_d <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_len       <= w_len_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_pressed_d <= w_pressed;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_len_nxt   = r_len;
        w_pass_nxt  = r_pass;
        w_fail_nxt  = r_fail;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_step_nxt = 7'd0;
                    w_len_nxt  = round_len;
                    w_pass_nxt = 1'b0;
                    if (round_len_ok(round_len)) begin
                        w_fail_nxt  = 1'b0;
                        w_state_nxt = ST_WAIT_PRESS;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = ST_RESULT;
                    end
                end
            end

            ST_WAIT_PRESS: begin
                if (w_edge != 4'd0) begin
                    if (is_onehot4(w_edge) && (w_sym == exp_sym)) begin
                        w_state_nxt = ST_WAIT_RELEASE;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = ST_RESULT;
                    end
                end else if (w_timeout) begin
                    w_fail_nxt  = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
            end

            ST_WAIT_RELEASE: begin
                if (w_edge != 4'd0) begin
                    w_fail_nxt  = 1'b1;
                    w_state_nxt = ST_RESULT;
                end else if (w_pressed == 4'd0) begin
                    w_step_nxt = r_step + 7'd1;
                    if (w_step_nxt == r_len) begin
                        w_pass_nxt  = 1'b1;
                        w_state_nxt = ST_RESULT;
                    end else begin
                        w_state_nxt = ST_WAIT_PRESS;
                    end
                end
            end

            ST_RESULT: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign exp_idx    = r_step;
    assign step       = r_step;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_RESULT);
    assign pass       = r_pass;
    assign fail       = r_fail;
    assign press_leds = busy ? w_pressed : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_simon_input_checker.sv
// ============================================================================
// Module      : tb_simon_input_checker
// Description : Self-checking bench for simon_input_checker (DEBOUNCE=4,
//               TIMEOUT=1000) with directed scenarios and randomized rounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_input_checker;

    localparam int DEB = 4;
    localparam int TO  = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       start;
    logic [6:0] round_len;
    logic [6:0] exp_idx;
    logic [1:0] exp_sym;
    logic       busy, done, pass, fail;
    logic [3:0] press_leds;
    logic [6:0] step;

    logic [1:0] seq_mem [0:127];

    int         checks    = 0;
    int         failures  = 0;
    int         done_cnt  = 0;
    logic       last_pass = 1'b0;
    logic       last_fail = 1'b0;
    logic [6:0] last_step = 7'd0;

    always #5 clk = ~clk;

    assign exp_sym = seq_mem[exp_idx];

    simon_input_checker #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .start      (start),
        .round_len  (round_len),
        .exp_idx    (exp_idx),
        .exp_sym    (exp_sym),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .press_leds (press_leds),
        .step       (step)
    );

    // Records every done pulse and the verdict visible alongside it.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_pass = pass;
            last_fail = fail;
            last_step = step;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_round(input logic [6:0] len);
        start     = 1'b1;
        round_len = len;
        cyc(1);
        start     = 1'b0;
    endtask

    task automatic press_key(input logic [1:0] k, input int hold, input int gap);
        key = ~(4'b0001 << k);
        cyc(hold);
        key = 4'hF;
        cyc(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 4'hF; start = 1'b0; round_len = 7'd0;
        for (int i = 0; i < 128; i++) seq_mem[i] = 2'd0;
        cyc(3);
        checks++;
        if ({busy, done, pass, fail} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0000", {busy, done, pass, fail});
        end
        checks++;
        if ({step, exp_idx, press_leds} !== 18'd0) begin
            failures++;
            $display("FAIL reset_counts: step=%0d exp_idx=%0d leds=%b required all 0", step, exp_idx, press_leds);
        end
        rst = 1'b0;
        cyc(2);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_idle: busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_invalid_len();
        logic [6:0] lens [3];
        int n0;
        lens[0] = 7'd0; lens[1] = 7'd101; lens[2] = 7'd127;
        for (int i = 0; i < 3; i++) begin
            n0 = done_cnt;
            start_round(lens[i]);
            checks++;
            if ({done, fail, pass} !== 3'b110) begin
                failures++;
                $display("FAIL invalid_len_%0d: done/fail/pass=%b required 110", lens[i], {done, fail, pass});
            end
            cyc(1);
            checks++;
            if ({done, busy, fail, done_cnt} !== {3'b001, n0 + 1}) begin
                failures++;
                $display("FAIL invalid_len_after_%0d: done/busy/fail=%b pulses=%0d required 001 and %0d",
                         lens[i], {done, busy, fail}, done_cnt - n0, 1);
            end
        end
    endtask

    task automatic test_pass_seq();
        int n0;
        seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
        n0 = done_cnt;
        start_round(7'd3);
        checks++;
        if ({busy, pass, fail, step} !== {3'b100, 7'd0}) begin
            failures++;
            $display("FAIL pass_start: busy/pass/fail=%b step=%0d required 100 step 0", {busy, pass, fail}, step);
        end
        for (int i = 0; i < 3; i++) begin
            key = ~(4'b0001 << seq_mem[i]);
            cyc(9);
            checks++;
            if (press_leds !== (4'b0001 << seq_mem[i])) begin
                failures++;
                $display("FAIL pass_leds_%0d: got %b required %b", i, press_leds, 4'b0001 << seq_mem[i]);
            end
            if (i == 1) begin
                start = 1'b1; round_len = 7'd0;
                cyc(1);
                start = 1'b0;
                checks++;
                if ({done, fail} !== 2'b00) begin
                    failures++;
                    $display("FAIL start_while_busy: done/fail=%b required 00", {done, fail});
                end
            end else begin
                cyc(1);
            end
            key = 4'hF;
            cyc(10);
            if (i < 2) begin
                checks++;
                if ({step, exp_idx} !== {7'(i + 1), 7'(i + 1)}) begin
                    failures++;
                    $display("FAIL pass_step_%0d: step=%0d exp_idx=%0d required %0d", i, step, exp_idx, i + 1);
                end
            end
        end
        checks++;
        if ((done_cnt - n0) !== 1 || {last_pass, last_fail, last_step} !== {2'b10, 7'd3}) begin
            failures++;
            $display("FAIL pass_result: pulses=%0d pass=%b fail=%b step=%0d required 1 1 0 3",
                     done_cnt - n0, last_pass, last_fail, last_step);
        end
        checks++;
        if ({busy, pass, press_leds} !== {2'b01, 4'b0000}) begin
            failures++;
            $display("FAIL pass_idle_hold: busy=%b pass=%b leds=%b required 0 1 0000", busy, pass, press_leds);
        end
    endtask

    task automatic test_wrong_key();
        int   n0;
        logic seen;
        seq_mem[0] = 2'd1; seq_mem[1] = 2'd1;
        n0 = done_cnt;
        start_round(7'd2);
        press_key(2'd1, 10, 10);
        checks++;
        if (step !== 7'd1) begin
            failures++;
            $display("FAIL wrong_first_step: got %0d required 1", step);
        end
        key  = 4'b1011;
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            cyc(1);
            seen = press_leds[2];
        end
        checks++;
        if (!seen || done !== 1'b0) begin
            failures++;
            $display("FAIL wrong_edge: seen=%b done=%b required 1 0", seen, done);
        end
        cyc(1);
        checks++;
        if ({done, fail, pass, step} !== {3'b110, 7'd1}) begin
            failures++;
            $display("FAIL wrong_done: done/fail/pass=%b step=%0d required 110 step 1", {done, fail, pass}, step);
        end
        key = 4'hF;
        cyc(10);
        checks++;
        if ((done_cnt - n0) !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrong_single_pulse: pulses=%0d busy=%b required 1 0", done_cnt - n0, busy);
        end
    endtask

    task automatic test_held_key();
        int n0;
        key = 4'b1110;
        cyc(10);
        checks++;
        if (press_leds !== 4'b0000) begin
            failures++;
            $display("FAIL idle_leds: got %b required 0000", press_leds);
        end
        seq_mem[0] = 2'd0;
        n0 = done_cnt;
        start_round(7'd1);
        cyc(5);
        checks++;
        if ({busy, step, press_leds} !== {1'b1, 7'd0, 4'b0001} || done_cnt !== n0) begin
            failures++;
            $display("FAIL held_ignored: busy=%b step=%0d leds=%b pulses=%0d required 1 0 0001 0",
                     busy, step, press_leds, done_cnt - n0);
        end
        key = 4'hF;
        cyc(10);
        key = 4'b1110;
        cyc(10);
        checks++;
        if (busy !== 1'b1 || done_cnt !== n0) begin
            failures++;
            $display("FAIL held_wait_release: busy=%b pulses=%0d required 1 0", busy, done_cnt - n0);
        end
        key = 4'hF;
        cyc(10);
        checks++;
        if ((done_cnt - n0) !== 1 || {last_pass, last_fail} !== 2'b10) begin
            failures++;
            $display("FAIL held_result: pulses=%0d pass/fail=%b required 1 10", done_cnt - n0, {last_pass, last_fail});
        end
    endtask

    task automatic test_bounce();
        int n0;
        seq_mem[0] = 2'd3; seq_mem[1] = 2'd3;
        n0 = done_cnt;
        start_round(7'd2);
        for (int i = 0; i < 10; i++) begin
            key[3] = ~key[3];
            cyc(2);
        end
        key = 4'hF;
        cyc(10);
        checks++;
        if ({busy, step} !== {1'b1, 7'd0} || done_cnt !== n0) begin
            failures++;
            $display("FAIL bounce: busy=%b step=%0d pulses=%0d required 1 0 0", busy, step, done_cnt - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = done_cnt;
        press_key(2'd3, 10, 10);
        key = 4'b0111;
        cyc(10);
        checks++;
        if ({busy, step, press_leds} !== {1'b1, 7'd1, 4'b1000}) begin
            failures++;
            $display("FAIL pre_reset: busy=%b step=%0d leds=%b required 1 1 1000", busy, step, press_leds);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, fail, step, press_leds} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset: busy/done/pass/fail=%b step=%0d leds=%b required all 0",
                     {busy, done, pass, fail}, step, press_leds);
        end
        cyc(3);
        key = 4'hF;
        rst = 1'b0;
        cyc(10);
        checks++;
        if (done_cnt !== n0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: pulses=%0d busy=%b required 0 0", done_cnt - n0, busy);
        end
        start_round(7'd0);
        cyc(2);
        checks++;
        if ((done_cnt - n0) !== 1 || last_fail !== 1'b1) begin
            failures++;
            $display("FAIL reset_then_zero: pulses=%0d fail=%b required 1 1", done_cnt - n0, last_fail);
        end
    endtask

    task automatic test_timeout();
        int n0;
        int n;
        seq_mem[0] = 2'd1;
        n0 = done_cnt;
        start_round(7'd1);
`ifdef SIMON_INPUT_TIMEOUT_EN
        n = 0;
        while (done_cnt == n0 && n < TO + 100) begin
            cyc(1);
            n++;
        end
        checks++;
        if (done_cnt == n0 || n < TO - 5 || n > TO + 5 || last_fail !== 1'b1) begin
            failures++;
            $display("FAIL timeout: pulses=%0d cycles=%0d fail=%b required 1 ~%0d 1", done_cnt - n0, n, last_fail, TO);
        end
        cyc(2);
`else
        n = TO + 100;
        cyc(n);
        checks++;
        if (busy !== 1'b1 || done_cnt !== n0) begin
            failures++;
            $display("FAIL no_timeout: busy=%b pulses=%0d after %0d cycles required 1 0", busy, done_cnt - n0, n);
        end
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
`endif
    endtask

    task automatic test_random();
        int         len, mode, w, n0, hold, gap, exp_step;
        logic       exp_pass;
        logic [1:0] other;
        for (int r = 0; r < 30; r++) begin
            len  = int'($urandom_range(1, 6));
            mode = int'($urandom_range(0, 3));
            w    = int'($urandom_range(0, len - 1));
            for (int i = 0; i < len; i++) seq_mem[i] = 2'($urandom_range(0, 3));
            exp_pass = (mode >= 2);
            exp_step = exp_pass ? len : w;
            n0 = done_cnt;
            start_round(7'(len));
            for (int i = 0; i < len; i++) begin
                hold  = int'($urandom_range(8, 14));
                gap   = int'($urandom_range(8, 14));
                other = seq_mem[i] ^ 2'($urandom_range(1, 3));
                if (mode == 0 && i == w) begin
                    press_key(other, hold, gap);
                    break;
                end else if (mode == 1 && i == w) begin
                    key = ~(4'b0001 << seq_mem[i]);
                    cyc(hold);
                    key[other] = 1'b0;
                    cyc(hold);
                    key = 4'hF;
                    cyc(gap);
                    break;
                end else begin
                    press_key(seq_mem[i], hold, gap);
                end
            end
            cyc(3);
            checks++;
            if ((done_cnt - n0) !== 1 || last_step !== 7'(exp_step) ||
                last_pass !== exp_pass || last_fail !== !exp_pass || busy !== 1'b0) begin
                failures++;
                $display("FAIL random_round_%0d: pulses=%0d step=%0d pass=%b fail=%b busy=%b required 1 %0d %b %b 0",
                         r, done_cnt - n0, last_step, last_pass, last_fail, busy, exp_step, exp_pass, !exp_pass);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_len();
        test_pass_seq();
        test_wrong_key();
        test_held_key();
        test_bounce();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
